// File: rtl/mac_array_os.sv
// Output-stationary ROWS x COLS signed MAC array with its own job controller.
// Callers stream unskewed act/wgt vectors; the block skews them internally,
// accumulates into per-PE psums and drains the result one row per handshake.
module mac_array_os #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned K_W    = 16,
    parameter int unsigned SAT    = 0,
    localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    input  logic                    cfg_acc,
    input  logic [ROWS*ACC_W-1:0]   C_data,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*DATA_W-1:0]  act_vec,
    input  logic [COLS*DATA_W-1:0]  wgt_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*ACC_W-1:0]   out_row,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_last
);

    localparam int unsigned FLUSH_LEN = ROWS + COLS - 1;

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

    state_e           state_q, state_d;
    logic [K_W-1:0]   klen_q;
    logic [K_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic accept;
    logic preload;

    assign accept  = in_valid && in_ready;
    assign preload = (state_q == StIdle) && start && !cfg_acc;

    // Signed MAC step: sign-extended product added, clamped or wrapped.
    function automatic logic [ACC_W-1:0] mac_add(input logic [ACC_W-1:0]  acc,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] prod;
        logic signed [ACC_W:0]      sum;
        prod = $signed(a) * $signed(b);
        sum  = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'(prod);
        if (SAT != 0 && sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return sum[ACC_W-1:0];
    endfunction

    // Controller state, beat/flush counter, drain index and latched job length.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            klen_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (state_q == StIdle && start) begin
                klen_q <= k_len;
            end
        end
    end

    // Next-state logic: LOAD counts accepted beats, FLUSH counts fixed cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (k_len != '0) ? StLoad : StDrain;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (cnt_q == klen_q - K_W'(1)) begin
                        cnt_d   = '0;
                        state_d = StFlush;
                    end else begin
                        cnt_d = cnt_q + K_W'(1);
                    end
                end
            end
            StFlush: begin
                if (cnt_q == K_W'(FLUSH_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + K_W'(1);
                end
            end
            StDrain: begin
                if (out_ready) begin
                    if (idx_q == IDX_W'(ROWS - 1)) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Row/column entry points after the input skew chains.
    logic [DATA_W-1:0] a_in   [ROWS];
    logic              a_in_v [ROWS];
    logic [DATA_W-1:0] w_in   [COLS];
    logic              w_in_v [COLS];

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_act_skew
        if (gi == 0) begin : g_direct
            assign a_in[gi]   = act_vec[DATA_W-1:0];
            assign a_in_v[gi] = accept;
        end else begin : g_chain
            logic [DATA_W-1:0] sk   [gi];
            logic              sk_v [gi];
            // Delay row gi by gi cycles so it meets its weights on the diagonal.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int k = 0; k < gi; k++) begin
                        sk[k]   <= '0;
                        sk_v[k] <= 1'b0;
                    end
                end else begin
                    sk[0]   <= act_vec[gi*DATA_W +: DATA_W];
                    sk_v[0] <= accept;
                    for (int k = 1; k < gi; k++) begin
                        sk[k]   <= sk[k-1];
                        sk_v[k] <= sk_v[k-1];
                    end
                end
            end
            assign a_in[gi]   = sk[gi-1];
            assign a_in_v[gi] = sk_v[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_wgt_skew
        if (gj == 0) begin : g_direct
            assign w_in[gj]   = wgt_vec[DATA_W-1:0];
            assign w_in_v[gj] = accept;
        end else begin : g_chain
            logic [DATA_W-1:0] sk   [gj];
            logic              sk_v [gj];
            // Delay column gj by gj cycles.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int k = 0; k < gj; k++) begin
                        sk[k]   <= '0;
                        sk_v[k] <= 1'b0;
                    end
                end else begin
                    sk[0]   <= wgt_vec[gj*DATA_W +: DATA_W];
                    sk_v[0] <= accept;
                    for (int k = 1; k < gj; k++) begin
                        sk[k]   <= sk[k-1];
                        sk_v[k] <= sk_v[k-1];
                    end
                end
            end
            assign w_in[gj]   = sk[gj-1];
            assign w_in_v[gj] = sk_v[gj-1];
        end
    end

    // Per-PE operand registers (act flows right, wgt flows down) and psums.
    logic [DATA_W-1:0] a_pe   [ROWS][COLS];
    logic              a_pe_v [ROWS][COLS];
    logic [DATA_W-1:0] w_pe   [ROWS][COLS];
    logic              w_pe_v [ROWS][COLS];
    logic [ACC_W-1:0]  psum   [ROWS][COLS];
    logic [ACC_W-1:0]  psum_d [ROWS][COLS];

    // Psum next value: bias preload on start, else MAC when both tags are set.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                psum_d[i][j] = psum[i][j];
                if (preload) begin
                    psum_d[i][j] = C_data[i*ACC_W +: ACC_W];
                end else if (a_pe_v[i][j] && w_pe_v[i][j]) begin
                    psum_d[i][j] = mac_add(psum[i][j], a_pe[i][j], w_pe[i][j]);
                end
            end
        end
    end

    // Systolic operand shift and psum update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    a_pe[i][j]   <= '0;
                    a_pe_v[i][j] <= 1'b0;
                    w_pe[i][j]   <= '0;
                    w_pe_v[i][j] <= 1'b0;
                    psum[i][j]   <= '0;
                end
            end
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                a_pe[i][0]   <= a_in[i];
                a_pe_v[i][0] <= a_in_v[i];
                for (int j = 1; j < COLS; j++) begin
                    a_pe[i][j]   <= a_pe[i][j-1];
                    a_pe_v[i][j] <= a_pe_v[i][j-1];
                end
            end
            for (int j = 0; j < COLS; j++) begin
                w_pe[0][j]   <= w_in[j];
                w_pe_v[0][j] <= w_in_v[j];
                for (int i = 1; i < ROWS; i++) begin
                    w_pe[i][j]   <= w_pe[i-1][j];
                    w_pe_v[i][j] <= w_pe_v[i-1][j];
                end
            end
            psum <= psum_d;
        end
    end

    // Act and wgt tags travel identical distances, so they must always agree.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    assert (a_pe_v[i][j] == w_pe_v[i][j]);
                end
            end
        end
    end

    // Status and result stream outputs.
    always_comb begin
        busy      = (state_q != StIdle);
        in_ready  = (state_q == StLoad);
        out_valid = (state_q == StDrain);
        out_idx   = idx_q;
        out_last  = out_valid && (idx_q == IDX_W'(ROWS - 1));
        out_row   = '0;
        if (out_valid) begin
            for (int j = 0; j < COLS; j++) begin
                out_row[j*ACC_W +: ACC_W] = psum[idx_q][j];
            end
        end
    end

endmodule
